// File: rtl/xadc_drp_arbiter.sv
// xadc_drp_arbiter
//   Owns the XADC DRP and shares it between the EOC-driven result readout (auto)
//   and a software register-access port (sw). Only one DRP transaction is in
//   flight at a time. The side not served last wins when both request together,
//   and a DRDY timeout guarantees that a transaction always finishes.
//
// Ports
//   clk_i, rstn_i             DRP clock, asynchronous active-low reset
//   eoc_i, channel_i          end-of-conversion pulse and the converted channel
//   sw_req_i                  software request level, held until sw_ack_o
//   sw_we_i/addr_i/wdata_i    software transaction attributes, sampled at grant
//   sw_ack_o/rdata_o/err_o    software completion pulse, read data, timeout flag
//   drp_den_o/dwe_o/daddr_o/  DRP master side towards the XADC primitive
//   drp_di_o/do_i/drdy_i
//   res_valid_o/addr_o/data_o captured auto result (12-bit code, channel)
//   eoc_drop_o                auto result lost (overwritten or timed out)

module xadc_drp_arbiter #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        eoc_i,
  input  logic [4:0]  channel_i,
  input  logic        sw_req_i,
  input  logic        sw_we_i,
  input  logic [6:0]  sw_addr_i,
  input  logic [15:0] sw_wdata_i,
  output logic        sw_ack_o,
  output logic [15:0] sw_rdata_o,
  output logic        sw_err_o,
  output logic        drp_den_o,
  output logic        drp_dwe_o,
  output logic [6:0]  drp_daddr_o,
  output logic [15:0] drp_di_o,
  input  logic [15:0] drp_do_i,
  input  logic        drp_drdy_i,
  output logic        res_valid_o,
  output logic [4:0]  res_addr_o,
  output logic [11:0] res_data_o,
  output logic        eoc_drop_o
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_AUTO = 2'd1,
    WAIT_SW   = 2'd2
  } state_t;

  state_t      state, state_d;
  logic        pend, pend_d;
  logic [4:0]  pend_ch, pend_ch_d;
  // rr_sw = 1 means software has priority on the next simultaneous request
  logic        rr_sw, rr_sw_d;
  logic [7:0]  cnt, cnt_d;
  logic        sw_is_write, sw_is_write_d;

  logic        den_d, dwe_d, ack_d, err_d, res_valid_d, drop_d;
  logic [6:0]  daddr_d;
  logic [15:0] di_d, rdata_d;
  logic [4:0]  res_addr_d;
  logic [11:0] res_data_d;
  logic        auto_cand, grant_auto, grant_sw;

  // All outputs are registered, so this block computes the next value of every
  // register. Pulse outputs default to 0 and every other output holds.
  always_comb begin
    state_d       = state;
    pend_d        = pend;
    pend_ch_d     = pend_ch;
    rr_sw_d       = rr_sw;
    cnt_d         = cnt;
    sw_is_write_d = sw_is_write;
    den_d         = 1'b0;
    dwe_d         = 1'b0;
    daddr_d       = drp_daddr_o;
    di_d          = drp_di_o;
    ack_d         = 1'b0;
    err_d         = 1'b0;
    rdata_d       = sw_rdata_o;
    res_valid_d   = 1'b0;
    res_addr_d    = res_addr_o;
    res_data_d    = res_data_o;
    drop_d        = 1'b0;

    // eoc_i bypasses the pending flag so that a fresh EOC seen in IDLE is
    // granted on the same edge
    auto_cand  = pend | eoc_i;
    grant_auto = auto_cand & (~sw_req_i | ~rr_sw);
    grant_sw   = sw_req_i & (~auto_cand | rr_sw);

    // A new EOC always becomes the pending one. If an older result was still
    // waiting, it is lost. An auto grant below clears pend again.
    if (eoc_i) begin
      pend_d    = 1'b1;
      pend_ch_d = channel_i;
      drop_d    = pend;
    end

    case (state)
      IDLE: begin
        if (grant_auto) begin
          state_d = WAIT_AUTO;
          den_d   = 1'b1;
          daddr_d = {2'b00, (eoc_i ? channel_i : pend_ch)};
          pend_d  = 1'b0;
          rr_sw_d = 1'b1;
          cnt_d   = 8'd0;
        end else if (grant_sw) begin
          state_d       = WAIT_SW;
          den_d         = 1'b1;
          dwe_d         = sw_we_i;
          daddr_d       = sw_addr_i;
          di_d          = sw_wdata_i;
          sw_is_write_d = sw_we_i;
          rr_sw_d       = 1'b0;
          cnt_d         = 8'd0;
        end
      end

      WAIT_AUTO, WAIT_SW: begin
        if (drp_drdy_i) begin
          state_d = IDLE;
          if (state == WAIT_AUTO) begin
            res_valid_d = 1'b1;
            res_addr_d  = drp_daddr_o[4:0];
            res_data_d  = drp_do_i[15:4];
          end else begin
            ack_d   = 1'b1;
            rdata_d = sw_is_write ? 16'h0000 : drp_do_i;
          end
        end else if (cnt == TIMEOUT_CNT) begin
          state_d = IDLE;
          if (state == WAIT_AUTO) begin
            drop_d = 1'b1;
          end else begin
            ack_d   = 1'b1;
            err_d   = 1'b1;
            rdata_d = 16'h0000;
          end
        end else begin
          cnt_d = cnt + 8'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state       <= IDLE;
      pend        <= 1'b0;
      pend_ch     <= 5'd0;
      rr_sw       <= 1'b0;
      cnt         <= 8'd0;
      sw_is_write <= 1'b0;
      drp_den_o   <= 1'b0;
      drp_dwe_o   <= 1'b0;
      drp_daddr_o <= 7'd0;
      drp_di_o    <= 16'd0;
      sw_ack_o    <= 1'b0;
      sw_err_o    <= 1'b0;
      sw_rdata_o  <= 16'd0;
      res_valid_o <= 1'b0;
      res_addr_o  <= 5'd0;
      res_data_o  <= 12'd0;
      eoc_drop_o  <= 1'b0;
    end else begin
      state       <= state_d;
      pend        <= pend_d;
      pend_ch     <= pend_ch_d;
      rr_sw       <= rr_sw_d;
      cnt         <= cnt_d;
      sw_is_write <= sw_is_write_d;
      drp_den_o   <= den_d;
      drp_dwe_o   <= dwe_d;
      drp_daddr_o <= daddr_d;
      drp_di_o    <= di_d;
      sw_ack_o    <= ack_d;
      sw_err_o    <= err_d;
      sw_rdata_o  <= rdata_d;
      res_valid_o <= res_valid_d;
      res_addr_o  <= res_addr_d;
      res_data_o  <= res_data_d;
      eoc_drop_o  <= drop_d;
    end
  end

endmodule

// File: tb/tb_xadc_drp_arbiter.sv
// tb_xadc_drp_arbiter
//   Drives xadc_drp_arbiter as both requesters and as the XADC DRP slave.
//   Expected behaviour comes from a transaction-level model: which side is
//   granted next, what the DRP access looks like and what completion it yields.

module tb_xadc_drp_arbiter;

  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        eoc = 1'b0;
  logic [4:0]  channel = 5'd0;
  logic        sw_req = 1'b0;
  logic        sw_we = 1'b0;
  logic [6:0]  sw_addr = 7'd0;
  logic [15:0] sw_wdata = 16'd0;
  logic        sw_ack, sw_err, den, dwe, res_valid, eoc_drop;
  logic [15:0] sw_rdata, di, drp_do;
  logic [6:0]  daddr;
  logic        drdy = 1'b0;
  logic [4:0]  res_addr;
  logic [11:0] res_data;

  int n_checks = 0;
  int n_errors = 0;
  // model state: 1 means software wins the next simultaneous request
  bit model_rr_sw = 1'b0;

  xadc_drp_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rstn_i(rstn), .eoc_i(eoc), .channel_i(channel),
    .sw_req_i(sw_req), .sw_we_i(sw_we), .sw_addr_i(sw_addr), .sw_wdata_i(sw_wdata),
    .sw_ack_o(sw_ack), .sw_rdata_o(sw_rdata), .sw_err_o(sw_err),
    .drp_den_o(den), .drp_dwe_o(dwe), .drp_daddr_o(daddr), .drp_di_o(di),
    .drp_do_i(drp_do), .drp_drdy_i(drdy),
    .res_valid_o(res_valid), .res_addr_o(res_addr), .res_data_o(res_data),
    .eoc_drop_o(eoc_drop)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic e, input logic [4:0] ch, input logic req,
                               input logic we, input logic [6:0] addr, input logic [15:0] wd);
    eoc      = e;
    channel  = ch;
    sw_req   = req;
    sw_we    = we;
    sw_addr  = addr;
    sw_wdata = wd;
  endtask

  // Every grant must appear exactly one cycle after the arbiter could take it.
  task automatic waitDen(input string tag);
    int seen = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      eoc = 1'b0;
      if (den) begin
        seen = i;
        break;
      end
    end
    checkOutput({tag, "_den_latency"}, 64'(seen), 64'(1));
    checkOutput({tag, "_pulses_at_den"}, 64'({sw_ack, res_valid, eoc_drop, sw_err}), 64'(0));
  endtask

  task automatic checkGrant(input string tag, input bit is_auto, input logic [4:0] ch,
                            input logic we, input logic [6:0] addr, input logic [15:0] wd);
    checkOutput({tag, "_daddr"}, 64'(daddr), is_auto ? 64'({2'b00, ch}) : 64'(addr));
    checkOutput({tag, "_dwe"}, 64'(dwe), is_auto ? 64'(0) : 64'(we));
    if (!is_auto && we) checkOutput({tag, "_di"}, 64'(di), 64'(wd));
    model_rr_sw = is_auto;
  endtask

  // Called in the DEN cycle. lat > 0: DRDY lat cycles after DEN; lat == 0: no DRDY.
  task automatic finishTxn(input string tag, input bit is_auto, input logic [4:0] ch,
                           input logic we, input logic [6:0] addr, input int lat,
                           input logic [15:0] dout);
    logic [6:0] exp_addr;
    exp_addr = is_auto ? {2'b00, ch} : addr;
    if (lat > 0) begin
      repeat (lat) tick();
      checkOutput({tag, "_daddr_hold"}, 64'(daddr), 64'(exp_addr));
      checkOutput({tag, "_early_done"}, 64'({sw_ack, res_valid, eoc_drop}), 64'(0));
      drdy   = 1'b1;
      drp_do = dout;
      tick();
      drdy   = 1'b0;
      drp_do = 16'($urandom);
    end else begin
      repeat (TIMEOUT) tick();
      checkOutput({tag, "_early_timeout"}, 64'({sw_ack, res_valid, eoc_drop}), 64'(0));
      tick();
    end
    if (is_auto) begin
      checkOutput({tag, "_res_valid"}, 64'(res_valid), 64'(lat > 0));
      checkOutput({tag, "_eoc_drop"}, 64'(eoc_drop), 64'(lat == 0));
      if (lat > 0) begin
        checkOutput({tag, "_res_addr"}, 64'(res_addr), 64'(ch));
        checkOutput({tag, "_res_data"}, 64'(res_data), 64'(dout[15:4]));
      end
    end else begin
      checkOutput({tag, "_ack"}, 64'(sw_ack), 64'(1));
      checkOutput({tag, "_err"}, 64'(sw_err), 64'(lat == 0));
      checkOutput({tag, "_rdata"}, 64'(sw_rdata), (lat == 0 || we) ? 64'(0) : 64'(dout));
      sw_req = 1'b0;
    end
  endtask

  task automatic doSide(input string tag, input bit is_auto, input logic [4:0] ch,
                        input logic we, input logic [6:0] addr, input logic [15:0] wd,
                        input int lat, input logic [15:0] dout);
    waitDen(tag);
    checkGrant(tag, is_auto, ch, we, addr, wd);
    finishTxn(tag, is_auto, ch, we, addr, lat, dout);
  endtask

  initial begin
    int          kind, lat1, lat2;
    logic [4:0]  ch;
    logic        we;
    logic [6:0]  addr;
    logic [15:0] wd, d1, d2;
    bit          auto_first;

    drp_do = 16'($urandom);
    repeat (3) tick();
    checkOutput("reset_outs_a", 64'({den, dwe, daddr, di, sw_ack, sw_err}), 64'(0));
    checkOutput("reset_outs_b", 64'({sw_rdata, res_valid, res_addr, res_data, eoc_drop}), 64'(0));
    rstn = 1'b1;
    tick();

    // Simultaneous requests straight after reset: auto first, then sw, twice.
    for (int r = 0; r < 2; r++) begin
      applyStimulus(1'b1, 5'd7, 1'b1, 1'b0, 7'h03, 16'h0000);
      doSide("both_auto", 1'b1, 5'd7, 1'b0, 7'h03, 16'h0000, 2, 16'h1230);
      doSide("both_sw", 1'b0, 5'd7, 1'b0, 7'h03, 16'h0000, 1, 16'h5A5A);
      tick();
    end

    // EOC on channel 16 answered two cycles after DEN.
    applyStimulus(1'b1, 5'd16, 1'b0, 1'b0, 7'h00, 16'h0000);
    doSide("eoc16", 1'b1, 5'd16, 1'b0, 7'h00, 16'h0000, 2, 16'hABC0);
    tick();

    // Software write.
    applyStimulus(1'b0, 5'd0, 1'b1, 1'b1, 7'h41, 16'h2F0F);
    doSide("sw_wr", 1'b0, 5'd0, 1'b1, 7'h41, 16'h2F0F, 2, 16'hFFFF);
    tick();

    // Two EOCs during a software read: the first is overwritten.
    applyStimulus(1'b0, 5'd0, 1'b1, 1'b0, 7'h05, 16'h0000);
    waitDen("ovr_sw");
    checkGrant("ovr_sw", 1'b0, 5'd0, 1'b0, 7'h05, 16'h0000);
    eoc = 1'b1; channel = 5'd24;
    tick();
    checkOutput("ovr_drop_first", 64'(eoc_drop), 64'(0));
    channel = 5'd25;
    tick();
    eoc = 1'b0;
    checkOutput("ovr_drop_second", 64'(eoc_drop), 64'(1));
    tick();
    checkOutput("ovr_drop_pulse_end", 64'(eoc_drop), 64'(0));
    drdy = 1'b1; drp_do = 16'h7E57;
    tick();
    drdy = 1'b0; drp_do = 16'($urandom);
    checkOutput("ovr_sw_ack", 64'(sw_ack), 64'(1));
    checkOutput("ovr_sw_rdata", 64'(sw_rdata), 64'(16'h7E57));
    sw_req = 1'b0;
    doSide("ovr_auto", 1'b1, 5'd25, 1'b0, 7'h00, 16'h0000, 1, 16'h0010);
    tick();

    // Software read with no DRDY, then a late DRDY that must be ignored.
    applyStimulus(1'b0, 5'd0, 1'b1, 1'b0, 7'h30, 16'h0000);
    doSide("sw_to", 1'b0, 5'd0, 1'b0, 7'h30, 16'h0000, 0, 16'h0000);
    repeat (5) tick();
    drdy = 1'b1; drp_do = 16'hDEAD;
    tick();
    drdy = 1'b0;
    checkOutput("late_drdy_ignored", 64'({sw_ack, res_valid, eoc_drop, den}), 64'(0));
    tick();

    // Randomized single and simultaneous transactions.
    for (int t = 0; t < 40; t++) begin
      kind = int'($urandom_range(0, 2));
      ch   = 5'($urandom);
      we   = 1'($urandom);
      addr = 7'($urandom);
      wd   = 16'($urandom);
      d1   = 16'($urandom);
      d2   = 16'($urandom);
      lat1 = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6));
      lat2 = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6));
      repeat ($urandom_range(0, 3)) tick();
      if (kind == 0) begin
        applyStimulus(1'b1, ch, 1'b0, 1'b0, 7'h00, 16'h0000);
        doSide("rnd_auto", 1'b1, ch, 1'b0, 7'h00, 16'h0000, lat1, d1);
      end else if (kind == 1) begin
        applyStimulus(1'b0, 5'd0, 1'b1, we, addr, wd);
        doSide("rnd_sw", 1'b0, 5'd0, we, addr, wd, lat1, d1);
      end else begin
        auto_first = !model_rr_sw;
        applyStimulus(1'b1, ch, 1'b1, we, addr, wd);
        if (auto_first) begin
          doSide("rnd_both_auto", 1'b1, ch, we, addr, wd, lat1, d1);
          doSide("rnd_both_sw", 1'b0, ch, we, addr, wd, lat2, d2);
        end else begin
          doSide("rnd_both_sw", 1'b0, ch, we, addr, wd, lat1, d1);
          doSide("rnd_both_auto", 1'b1, ch, we, addr, wd, lat2, d2);
        end
      end
    end
    tick();

    // Reset in the middle of a software transaction.
    applyStimulus(1'b0, 5'd0, 1'b1, 1'b0, 7'h22, 16'h0000);
    waitDen("rst_sw");
    tick();
    tick();
    #2 rstn = 1'b0;
    #1;
    checkOutput("midrst_outs_a", 64'({den, dwe, daddr, di, sw_ack, sw_err}), 64'(0));
    checkOutput("midrst_outs_b", 64'({sw_rdata, res_valid, res_addr, res_data, eoc_drop}), 64'(0));
    sw_req = 1'b0;
    model_rr_sw = 1'b0;
    tick();
    rstn = 1'b1;
    drdy = 1'b1; drp_do = 16'h1111;
    tick();
    drdy = 1'b0;
    tick();
    checkOutput("midrst_no_ack", 64'({sw_ack, res_valid, eoc_drop, den}), 64'(0));
    applyStimulus(1'b1, 5'd3, 1'b0, 1'b0, 7'h00, 16'h0000);
    doSide("post_rst_auto", 1'b1, 5'd3, 1'b0, 7'h00, 16'h0000, 3, 16'h8880);
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
